mem_arbiter_n: RTL and testbench
================================

// Module: mem_arbiter_n
// PURPOSE
//  N-port arbiter that multiplexes cache-line read/write requests from NUM_REQ
//  upstream clients (I-cache, D-cache, prefetcher, ...) onto one downstream
//  memory/L2 port. Sits between the L1 caches and L2. Latches the winning request
//  so downstream address/data/op stay stable for the whole transaction.
//  Selectable fixed-priority or round-robin fairness.
// PARAMETERS
//  NUM_REQ  2    number of requesting clients (>=2); index 0 = highest fixed priority
//  ADDR_W   16   address width (lc3b_word-sized by default)
//  LINE_W   128  cache-line width (lc3b_cline-sized by default)
//  IDX_W    $clog2(NUM_REQ)  derived localparam, grant index width
// PORTS
//  clk        in   1               system clock, all logic on posedge
//  reset      in   1               synchronous, active-high reset
//  req_read   in   NUM_REQ         per-client read request
//  req_write  in   NUM_REQ         per-client write request
//  req_addr   in   NUM_REQ*ADDR_W  per-client address, client i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*LINE_W  per-client write line, same packing
//  req_resp   out  NUM_REQ         one-hot completion strobe to granted client
//  req_rdata  out  LINE_W          read line, broadcast to all clients (= mem_rdata)
//  mem_read   out  1               downstream read strobe
//  mem_write  out  1               downstream write strobe
//  mem_addr   out  ADDR_W          downstream address (registered)
//  mem_wdata  out  LINE_W          downstream write line (registered)
//  mem_resp   in   1               downstream completion
//  mem_rdata  in   LINE_W          downstream read line
// BEHAVIOUR
//  - Reset (sync): state=IDLE; mem_read=mem_write=0; mem_addr=0; mem_wdata=0;
//    req_resp=0; grant idx=0; rr pointer=NUM_REQ-1 (client 0 wins first).
//  - Client i is requesting when req_read[i]|req_write[i]. Both set: treated as write.
//  - FSM IDLE: if any client requesting, pick winner, register idx, op, addr, wdata;
//    next state RD or WR. No request: stay IDLE. mem_read/mem_write low in IDLE.
//  - RD/WR: mem_read (RD) or mem_write (WR) held 1 from registered op; mem_addr and
//    mem_wdata come only from the registers, never from live req_* inputs.
//  - In RD/WR, mem_resp=1 -> req_resp[idx]=1 same cycle (combinational), all other
//    bits 0; next state IDLE. Grant latency: request seen in IDLE -> strobe next cycle.
//  - Mandatory IDLE cycle between transactions; clients must drop or change their
//    request in the cycle after req_resp, so a completed request is never reissued.
//  - Requests arriving or withdrawn while RD/WR have no effect on the transaction.
//  - mem_resp while IDLE: ignored, req_resp stays 0.
//  - req_rdata = mem_rdata always; only the strobed client may sample it.
//  - Reset mid-transaction: next cycle IDLE, strobes low, transaction abandoned;
//    a late mem_resp is ignored per the IDLE rule.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: search starts at (rr_ptr+1) mod NUM_REQ, wrapping;
//    rr_ptr <= winner idx on each grant. No client starves for > NUM_REQ-1 grants.
//  Not defined: fixed priority, lowest requesting index wins; rr_ptr absent.
// TESTING
//  1 Reset, no requests, mem_resp pulsed -> mem_read/write/req_resp stay 0, mem_addr=0.
//  2 NUM_REQ=2, client1 read addr 0x1230; mem_resp after 3 cycles -> mem_read=1,
//    mem_addr=0x1230 for 3 cycles, req_resp=2'b10 in the mem_resp cycle, then IDLE.
//  3 Client0 write 0x4000 data 0xDEAD..; change req_addr/wdata mid-transaction ->
//    mem_addr/mem_wdata unchanged; req_resp=2'b01.
//  4 NUM_REQ=3, all clients request continuously: RR_EN grant order 0,1,2,0;
//    without macro 0,0,0,0.
//  5 Client0 read granted, reset asserted mid-transaction -> next cycle mem_read=0,
//    state IDLE; subsequent mem_resp yields req_resp=0.
//  6 Client0 read+write both 1, addr 0x0010 -> mem_write=1, mem_read=0.

Source files
------------

// File: rtl/mem_arbiter_n.sv
// N-client cache-line arbiter onto a single downstream memory port; latches the winning request.
// Define ARB_ROUND_ROBIN_EN for round-robin fairness; otherwise fixed priority (index 0 highest).
module mem_arbiter_n #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LINE_W  = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LINE_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_resp,
  output logic [LINE_W-1:0]           req_rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic                        mem_resp,
  input  logic [LINE_W-1:0]           mem_rdata
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;

  logic [NUM_REQ-1:0]  req_any;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;

  assign req_any = req_read | req_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  int unsigned         cand;

  // Rotating search beginning one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + 32'd1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_any[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end
`else
  // Lowest requesting index wins; scanning downward leaves the lowest in place.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_any[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // Next-state logic: capture the winner in IDLE, hold until downstream completes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (win_found) begin
          idx_d   = win_idx;
          addr_d  = req_addr[32'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[32'(win_idx)*LINE_W +: LINE_W];
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d = win_idx;
`endif
          if (req_write[win_idx]) begin
            state_d     = ST_WR;
            mem_write_d = 1'b1;
          end else begin
            state_d    = ST_RD;
            mem_read_d = 1'b1;
          end
        end
      end
      ST_RD, ST_WR: begin
        if (mem_resp) begin
          state_d     = ST_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  // Completion strobe is combinational so the client sees it in the mem_resp cycle.
  always_comb begin
    req_resp = '0;
    if ((state_q != ST_IDLE) && mem_resp) req_resp[idx_q] = 1'b1;
  end

  assign req_rdata = mem_rdata;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed self-checking bench for mem_arbiter_n with three clients.
module tb_mem_arbiter_n;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_read, req_write, req_resp;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_wdata;
  logic [LW-1:0]   req_rdata, mem_wdata, mem_rdata;
  logic            mem_read, mem_write, mem_resp;
  logic [AW-1:0]   mem_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_n #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_resp(req_resp), .req_rdata(req_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  task automatic do_reset();
    reset     = 1'b1;
    req_read  = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%0b exp=0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%0b exp=0", mem_write); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    mem_resp = 1'b1;
    #1;
    checks++; if (req_resp !== 3'b000) begin failures++; $display("FAIL idle_resp_ignored got=%b exp=000", req_resp); end
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL idle_after_resp rd=%0b wr=%0b exp=0/0", mem_read, mem_write); end
  endtask

  task automatic test_read();
    req_read = 3'b010;
    req_addr[AW +: AW] = 16'h1230;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) mem_resp = 1'b1;
      #1;
      checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL read_strobe cyc=%0d rd=%0b wr=%0b exp=1/0", c, mem_read, mem_write); end
      checks++; if (mem_addr !== 16'h1230) begin failures++; $display("FAIL read_addr cyc=%0d got=%h exp=1230", c, mem_addr); end
      checks++; if (req_resp !== ((c == 2) ? 3'b010 : 3'b000)) begin failures++; $display("FAIL read_resp cyc=%0d got=%b exp=%b", c, req_resp, (c == 2) ? 3'b010 : 3'b000); end
    end
    @(negedge clk);
    req_read = '0;
    mem_resp = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || req_resp !== 3'b000) begin failures++; $display("FAIL read_back_idle rd=%0b resp=%b exp=0/000", mem_read, req_resp); end
  endtask

  task automatic test_write_hold();
    logic [LW-1:0] line;
    line = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    req_write = 3'b001;
    req_addr[0 +: AW] = 16'h4000;
    req_wdata[0 +: LW] = line;
    @(negedge clk);
    #1;
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL write_strobe rd=%0b wr=%0b exp=0/1", mem_read, mem_write); end
    checks++; if (mem_addr !== 16'h4000 || mem_wdata !== line) begin failures++; $display("FAIL write_payload addr=%h data=%h exp=4000/%h", mem_addr, mem_wdata, line); end
    req_addr[0 +: AW] = 16'hFFFF;
    req_wdata[0 +: LW] = ~line;
    req_read[2] = 1'b1;
    @(negedge clk);
    mem_resp = 1'b1;
    #1;
    checks++; if (mem_addr !== 16'h4000 || mem_wdata !== line) begin failures++; $display("FAIL write_hold addr=%h data=%h exp=4000/%h", mem_addr, mem_wdata, line); end
    checks++; if (req_resp !== 3'b001) begin failures++; $display("FAIL write_resp got=%b exp=001", req_resp); end
    @(negedge clk);
    mem_resp  = 1'b0;
    req_write = '0;
    req_read  = '0;
    #1;
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL write_back_idle got=%0b exp=0", mem_write); end
  endtask

  task automatic test_priority();
    req_read = 3'b110;
    req_addr[AW +: AW] = 16'h1111;
    req_addr[2*AW +: AW] = 16'h2222;
    @(negedge clk);
    mem_resp = 1'b1;
    #1;
    checks++; if (mem_addr !== 16'h1111) begin failures++; $display("FAIL prio_addr got=%h exp=1111", mem_addr); end
    checks++; if (req_resp !== 3'b010) begin failures++; $display("FAIL prio_resp got=%b exp=010", req_resp); end
    @(negedge clk);
    mem_resp = 1'b0;
    req_read = '0;
  endtask

  task automatic test_read_write_both();
    req_read[0]  = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0 +: AW] = 16'h0010;
    mem_rdata = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
    @(negedge clk);
    #1;
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL both_op rd=%0b wr=%0b exp=0/1", mem_read, mem_write); end
    checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL both_addr got=%h exp=0010", mem_addr); end
    checks++; if (req_rdata !== 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878) begin failures++; $display("FAIL rdata_pass got=%h", req_rdata); end
    mem_resp = 1'b1;
    #1;
    checks++; if (req_resp !== 3'b001) begin failures++; $display("FAIL both_resp got=%b exp=001", req_resp); end
    @(negedge clk);
    mem_resp  = 1'b0;
    req_read  = '0;
    req_write = '0;
  endtask

  task automatic test_arbitration();
    int exp_idx [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_idx = '{0, 1, 2, 0};
`else
    exp_idx = '{0, 0, 0, 0};
`endif
    do_reset();
    req_addr[0 +: AW]    = 16'h1000;
    req_addr[AW +: AW]   = 16'h1001;
    req_addr[2*AW +: AW] = 16'h1002;
    req_read = 3'b111;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      checks++; if (req_resp !== 3'(1 << exp_idx[g])) begin failures++; $display("FAIL arb_resp grant=%0d got=%b exp=%b", g, req_resp, 3'(1 << exp_idx[g])); end
      checks++; if (mem_addr !== 16'h1000 + 16'(exp_idx[g])) begin failures++; $display("FAIL arb_addr grant=%0d got=%h exp=%h", g, mem_addr, 16'h1000 + 16'(exp_idx[g])); end
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL arb_idle_gap grant=%0d got=%0b exp=0", g, mem_read); end
    end
    req_read = '0;
  endtask

  task automatic test_reset_mid();
    req_read[0] = 1'b1;
    req_addr[0 +: AW] = 16'h0055;
    @(negedge clk);
    #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0055) begin failures++; $display("FAIL mid_grant rd=%0b addr=%h exp=1/0055", mem_read, mem_addr); end
    reset    = 1'b1;
    req_read = '0;
    @(negedge clk);
    #1;
    checks++; if (mem_read !== 1'b0 || mem_addr !== 16'h0000) begin failures++; $display("FAIL mid_reset rd=%0b addr=%h exp=0/0000", mem_read, mem_addr); end
    reset    = 1'b0;
    mem_resp = 1'b1;
    #1;
    checks++; if (req_resp !== 3'b000) begin failures++; $display("FAIL late_resp got=%b exp=000", req_resp); end
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL post_late_idle rd=%0b wr=%0b exp=0/0", mem_read, mem_write); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_hold();
    test_priority();
    test_read_write_both();
    test_arbitration();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
